usb_uart_word_bridge: RTL
=========================

// Module: usb_uart_word_bridge
// PURPOSE
//  Sits between the usb_uart byte pipelines and application logic, one layer above the pin wrapper.
//  TX: buffers application words in a FIFO and serialises each word into WORD_BYTES bytes, LSB byte first.
//  RX: packs host bytes into words (first byte lands in bits [7:0]) and buffers them in a FIFO.
//  Decouples the application from USB's bursty byte timing.
// PARAMETERS
//  WORD_BYTES        4     bytes per word, 1..8; word width W = 8*WORD_BYTES
//  TX_DEPTH          16    TX FIFO depth in words, power of two, >=2
//  RX_DEPTH          16    RX FIFO depth in words, power of two, >=2
//  RX_TIMEOUT_CYCLES 48000 idle cycles before a partial RX word is flushed (1 ms at 48 MHz); timeout feature only
// PORTS
//  clk_48mhz      in  1     sole clock
//  reset_n        in  1     asynchronous, active-low reset
//  byte_out_data  out 8     to usb_uart uart_in_data
//  byte_out_valid out 1     to usb_uart uart_in_valid
//  byte_out_ready in  1     from usb_uart uart_in_ready
//  byte_in_data   in  8     from usb_uart uart_out_data
//  byte_in_valid  in  1     from usb_uart uart_out_valid
//  byte_in_ready  out 1     to usb_uart uart_out_ready
//  tx_word_data   in  W     application word to send to host
//  tx_word_valid  in  1     TX word valid
//  tx_word_ready  out 1     TX FIFO not full
//  rx_word_data   out W     word received from host
//  rx_word_valid  out 1     RX FIFO not empty
//  rx_word_ready  in  1     application pops RX word
//  rx_word_keep   out WORD_BYTES  per-byte valid mask of rx_word_data
//  tx_level       out $clog2(TX_DEPTH+1)  words held in TX FIFO
//  rx_level       out $clog2(RX_DEPTH+1)  words held in RX FIFO
// BEHAVIOUR
//  - Handshakes: transfer when valid&&ready on a rising edge. Once valid is high, it and its data hold until accepted.
//  - Reset (async assert, sync release): FIFOs emptied, packer/unpacker counters 0, timer 0.
//    Reset values: all valids 0, levels 0, byte_out_data 0, rx_word_data 0, tx_word_ready 1, byte_in_ready 1.
//    Reset mid-word discards partial bytes in both directions.
//  - FIFOs: ready = !full, valid = !empty, registered read data.
//    Push and pop in the same cycle leave the level unchanged. Push when full is ignored. Pop when empty is ignored.
//  - TX unpacker, states IDLE/SEND:
//    - IDLE: if TX FIFO is non-empty, pop and load the word; idx=0; go to SEND.
//    - SEND: byte_out_data = word[8*idx +: 8], byte_out_valid=1. On accept, idx++.
//    - After the accept at idx=WORD_BYTES-1: pop the next word if present and stay in SEND (back-to-back, no bubble); else go to IDLE.
//    - Latency: word accepted in cycle N with both FIFO and unpacker empty -> first byte valid in cycle N+2.
//  - RX packer, counter cnt 0..WORD_BYTES:
//    - Byte accepted: stored at [8*cnt +: 8], cnt++.
//    - cnt==WORD_BYTES: push the word with keep all-ones, then clear cnt. byte_in_ready = !(cnt==WORD_BYTES && rx FIFO full).
//    - Push and a new byte accept in the same cycle are allowed (full throughput: 1 byte/cycle).
//    - Unused bytes of a pushed word are 0.
//  - WORD_BYTES=1: pure byte FIFOs; keep is always 1.
// CONFIGURATION
//  USB_WORD_BRIDGE_RX_TIMEOUT_EN defined:
//    - Idle timer counts while 0<cnt<WORD_BYTES and no byte is accepted; any accepted byte clears it.
//    - When the timer reaches RX_TIMEOUT_CYCLES-1: force-push the partial word.
//      keep = (1<<cnt)-1, upper bytes 0, cnt=0.
//    - If RX FIFO is full at that point: hold the flush request and block bytes until the push succeeds.
//    - A byte arriving in the expiry cycle wins: it is stored and the timer restarts.
//  Not defined: no timer logic, RX_TIMEOUT_CYCLES ignored, partial words wait indefinitely,
//    rx_word_keep tied to all ones.
// STRUCTURE
//  usb_word_bridge_pkg: BYTE_W=8, level-width function (clog2), keep-mask helper function.
//  Sub-module usb_bridge_fifo #(WIDTH, DEPTH): sync FIFO, instantiated for TX (W bits) and RX (W+WORD_BYTES bits incl. keep).
//  Packer, unpacker and timer live in this module.
// TESTING
//  1 WORD_BYTES=4: push 0x44332211, byte_out_ready=1 -> bytes 11,22,33,44 on cycles N+2..N+5; tx_level back to 0.
//  2 Bytes 01..08 at 1/cycle, rx_word_ready=1 -> rx words 0x04030201, 0x08070605, keep=0xF, byte_in_ready stays 1.
//  3 rx_word_ready=0, send 4*RX_DEPTH+4 bytes
//    -> rx_level=RX_DEPTH; byte_in_ready falls after the byte that completes word RX_DEPTH+1;
//       no byte lost after draining.
//  4 byte_out_ready toggling 50% with 3 queued words -> 12 bytes in order, no duplicates; tx_word_ready low only when tx_level=TX_DEPTH.
//  5 TIMEOUT_EN, RX_TIMEOUT_CYCLES=16: send AA,BB then idle -> word 0x0000BBAA with keep=0x3 after 16 idle cycles.
//    Byte in expiry cycle -> no flush.
//  6 Assert reset_n=0 mid-TX-word and with cnt=2
//    -> all valids 0 immediately; after release, levels 0 and no stale bytes are emitted.

Source files
------------

// File: rtl/usb_word_bridge_pkg.sv
// Shared types and helpers for the usb_uart word bridge.
package usb_word_bridge_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [7:0] keep_mask(input int nbytes);
        return 8'((1 << nbytes) - 1);
    endfunction

endpackage

// File: rtl/usb_bridge_fifo.sv
// Synchronous FIFO, power-of-two depth, head word read from registered storage.
module usb_bridge_fifo
    import usb_word_bridge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_data_i,
    input  logic                    pop_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [WIDTH-1:0]        head_o,
    output logic [lvl_w(DEPTH)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [LW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = cnt_q == LW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];
    assign level_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + LW'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - LW'(1);
            end
        end
    end

endmodule

// File: rtl/usb_uart_word_bridge.sv
// Word <-> byte bridge above usb_uart; partial-RX-word flush via USB_WORD_BRIDGE_RX_TIMEOUT_EN.
module usb_uart_word_bridge
    import usb_word_bridge_pkg::*;
#(
    parameter int WORD_BYTES        = 4,
    parameter int TX_DEPTH          = 16,
    parameter int RX_DEPTH          = 16,
    parameter int RX_TIMEOUT_CYCLES = 48000
) (
    input  logic                       clk_48mhz,
    input  logic                       reset_n,
    output logic [7:0]                 byte_out_data,
    output logic                       byte_out_valid,
    input  logic                       byte_out_ready,
    input  logic [7:0]                 byte_in_data,
    input  logic                       byte_in_valid,
    output logic                       byte_in_ready,
    input  logic [8*WORD_BYTES-1:0]    tx_word_data,
    input  logic                       tx_word_valid,
    output logic                       tx_word_ready,
    output logic [8*WORD_BYTES-1:0]    rx_word_data,
    output logic                       rx_word_valid,
    input  logic                       rx_word_ready,
    output logic [WORD_BYTES-1:0]      rx_word_keep,
    output logic [lvl_w(TX_DEPTH)-1:0] tx_level,
    output logic [lvl_w(RX_DEPTH)-1:0] rx_level
);

    localparam int W  = BYTE_W * WORD_BYTES;
    localparam int CW = $clog2(WORD_BYTES + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WORD_BYTES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WORD_BYTES);
`ifdef USB_WORD_BRIDGE_RX_TIMEOUT_EN
    localparam int RXW = W + WORD_BYTES;
`else
    localparam int RXW = W;
`endif

    if (WORD_BYTES < 1 || WORD_BYTES > 8) begin : g_bad_word_bytes
        $error("WORD_BYTES must be within 1..8");
    end
    if (RX_TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("RX_TIMEOUT_CYCLES must be at least 2");
    end

    tx_state_e     tx_state_q;
    logic [W-1:0]  tx_word_q;
    logic [CW-1:0] tx_idx_q;
    logic [W-1:0]  tx_head;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_pop;
    logic          tx_accept;
    logic          tx_last;

    usb_bridge_fifo #(.WIDTH(W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i       (clk_48mhz),
        .rst_ni      (reset_n),
        .push_i      (tx_word_valid),
        .push_data_i (tx_word_data),
        .pop_i       (tx_pop),
        .full_o      (tx_full),
        .empty_o     (tx_empty),
        .head_o      (tx_head),
        .level_o     (tx_level)
    );

    assign tx_word_ready  = !tx_full;
    assign tx_accept      = (tx_state_q == TX_SEND) && byte_out_ready;
    assign tx_last        = tx_idx_q == LAST_IDX;
    assign tx_pop         = !tx_empty
                          && ((tx_state_q == TX_IDLE) || (tx_accept && tx_last));
    assign byte_out_valid = tx_state_q == TX_SEND;
    assign byte_out_data  = tx_word_q[BYTE_W-1:0];

    // The word shifts down one byte per accept, so the output byte is always bit 0.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_word_q  <= '0;
            tx_idx_q   <= '0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_word_q  <= tx_head;
                        tx_idx_q   <= '0;
                        tx_state_q <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_accept) begin
                        if (tx_last) begin
                            tx_idx_q <= '0;
                            if (tx_pop) begin
                                tx_word_q <= tx_head;
                            end else begin
                                tx_state_q <= TX_IDLE;
                            end
                        end else begin
                            tx_word_q <= tx_word_q >> BYTE_W;
                            tx_idx_q  <= tx_idx_q + CW'(1);
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    logic [CW-1:0]  rx_cnt_q;
    logic [W-1:0]   rx_acc_q;
    logic [RXW-1:0] rx_push_data;
    logic [RXW-1:0] rx_head;
    logic           rx_full;
    logic           rx_empty;
    logic           rx_push;
    logic           rx_flush;
    logic           byte_accept;

    assign byte_accept = byte_in_valid && byte_in_ready;
    assign rx_push     = (rx_cnt_q == FULL_CNT) || rx_flush;

    usb_bridge_fifo #(.WIDTH(RXW), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i       (clk_48mhz),
        .rst_ni      (reset_n),
        .push_i      (rx_push),
        .push_data_i (rx_push_data),
        .pop_i       (rx_word_ready),
        .full_o      (rx_full),
        .empty_o     (rx_empty),
        .head_o      (rx_head),
        .level_o     (rx_level)
    );

    assign rx_word_valid = !rx_empty;
    assign rx_word_data  = rx_head[W-1:0];

`ifdef USB_WORD_BRIDGE_RX_TIMEOUT_EN
    localparam int TW = $clog2(RX_TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] EXPIRE = TW'(RX_TIMEOUT_CYCLES - 1);

    logic [TW-1:0]         timer_q;
    logic                  flush_q;
    logic                  partial;
    logic                  expire;
    logic [WORD_BYTES-1:0] rx_keep_in;

    assign partial  = (rx_cnt_q != '0) && (rx_cnt_q != FULL_CNT);
    // A byte landing in the expiry cycle cancels the flush.
    assign expire   = partial && !flush_q && !byte_accept && (timer_q == EXPIRE);
    assign rx_flush = expire || flush_q;

    assign byte_in_ready = !flush_q && !((rx_cnt_q == FULL_CNT) && rx_full);
    assign rx_keep_in    = WORD_BYTES'(keep_mask(int'(rx_cnt_q)));
    assign rx_push_data  = {rx_keep_in, rx_acc_q};
    assign rx_word_keep  = rx_head[RXW-1:W];

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= rx_flush && rx_full;
            if (byte_accept || rx_flush) begin
                timer_q <= '0;
            end else if (partial) begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end
`else
    assign rx_flush      = 1'b0;
    assign byte_in_ready = !((rx_cnt_q == FULL_CNT) && rx_full);
    assign rx_push_data  = rx_acc_q;
    assign rx_word_keep  = '1;
`endif

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            rx_cnt_q <= '0;
            rx_acc_q <= '0;
        end else if (rx_push && !rx_full) begin
            if (byte_accept) begin
                rx_acc_q <= W'(byte_in_data);
                rx_cnt_q <= CW'(1);
            end else begin
                rx_acc_q <= '0;
                rx_cnt_q <= '0;
            end
        end else if (byte_accept) begin
            rx_acc_q[BYTE_W*rx_cnt_q +: BYTE_W] <= byte_in_data;
            rx_cnt_q <= rx_cnt_q + CW'(1);
        end
    end

endmodule
